// File: rtl/btb_update_sched_pkg.sv
// ============================================================================
// Module      : btb_update_sched_pkg
// Description : Shared types and constants for the BTB update scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btb_update_sched_pkg;

    localparam int VLEN               = 64;
    localparam int BTB_ENTRIES        = 64;
    localparam int BTB_UPD_FIFO_DEPTH = 4;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target_address;
    } branchpredict_t;

endpackage

`default_nettype wire

// File: rtl/btb_update_sched_arb.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter with enable, one-hot grant, rotating pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int NR_REQ = 2,
    localparam int PTR_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [NR_REQ-1:0] req_i,
    output logic [NR_REQ-1:0] gnt_o
);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_next;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    // Search starts at the pointer; the pointer moves past the winner.
    always_comb begin
        gnt_o      = '0;
        w_ptr_next = r_ptr;
        w_idx      = '0;
        w_found    = 1'b0;
        if (en_i) begin
            for (int i = 0; i < NR_REQ; i++) begin
                w_idx = PTR_W'((int'(r_ptr) + i) % NR_REQ);
                if (!w_found && req_i[w_idx]) begin
                    w_found      = 1'b1;
                    gnt_o[w_idx] = 1'b1;
                    w_ptr_next   = PTR_W'((int'(w_idx) + 1) % NR_REQ);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/btb_update_sched.sv
// ============================================================================
// Module      : btb_update_sched
// Description : Arbitrates BTB updates into a FIFO and sequences flush walks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_update_sched
    import btb_update_sched_pkg::*;
#(
    parameter  int NR_REQ     = 2,
    parameter  int FIFO_DEPTH = BTB_UPD_FIFO_DEPTH,
    parameter  int NR_ENTRIES = BTB_ENTRIES,
    localparam int PW         = $clog2(FIFO_DEPTH),
    localparam int IW         = $clog2(NR_ENTRIES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NR_REQ-1:0] req_valid_i,
    input  branchpredict_t    req_data_i [NR_REQ],
    output logic [NR_REQ-1:0] req_ready_o,
    input  logic              flush_bp_i,
    output logic              upd_valid_o,
    output branchpredict_t    upd_o,
    input  logic              upd_ready_i,
    output logic              inv_we_o,
    output logic [IW-1:0]     inv_idx_o,
    output logic              busy_o,
    output logic [PW:0]       occupancy_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WALK = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_next;
    branchpredict_t  r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    logic [IW-1:0]   r_cnt;

    logic            w_idle;
    logic            w_full;
    logic            w_empty;
    logic            w_upd_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_arb_en;
    logic [NR_REQ-1:0] w_gnt;
    branchpredict_t  w_sel_data;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_full      = (r_count == (PW+1)'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_upd_valid = w_idle && !w_empty && !flush_bp_i;
    assign w_pop       = w_upd_valid && upd_ready_i;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign w_arb_en    = w_idle && !flush_bp_i && (!w_full || w_pop);

    rr_arbiter #(
        .NR_REQ (NR_REQ)
    ) i_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (w_arb_en),
        .req_i (req_valid_i),
        .gnt_o (w_gnt)
    );

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_data = req_data_i[i];
            end
        end
    end

    // Granted requests carrying an invalid payload are consumed but not queued.
    assign w_push = (|w_gnt) && w_sel_data.valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (flush_bp_i) w_state_next = ST_WALK;
            ST_WALK: if (!flush_bp_i && r_cnt == IW'(NR_ENTRIES-1)) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        inv_we_o    = (r_state == ST_WALK);
        inv_idx_o   = inv_we_o ? r_cnt : '0;
        busy_o      = (r_state == ST_WALK);
        upd_valid_o = w_upd_valid;
        req_ready_o = w_gnt;
        upd_o       = r_mem[r_rd_ptr];
        occupancy_o = r_count;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_bp_i) begin
            r_cnt <= '0;
        end else if (r_state == ST_WALK) begin
            r_cnt <= r_cnt + IW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_bp_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_sel_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire
